sorted_drain: RTL and testbench
===============================

Name: sorted_drain

Overview:
- Consumer end of the 6-way sort network. Captures one frame of six sorted values (n0 = largest … n5 = smallest) in a single valid/ready transfer and replays them as a serial stream, one value per accepted beat.
- Downstream logic reads ranked values one at a time, in descending order, with backpressure.
- Frame boundaries are marked by a sequence index and a last flag.

Parameters:
- DATA_W, 10, width of each value.
- NUM, 6, values per frame; index width is clog2(NUM), 3 at default.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  frame on in_data is valid.
- in_ready  out  1  block can accept a frame.
- in_data  in  NUM*DATA_W  packed frame; n0 at bits [DATA_W-1:0], nK at [K*DATA_W +: DATA_W].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  current value.
- out_idx  out  3  rank of out_data (0 = largest).
- out_last  out  1  high with the beat whose out_idx = NUM-1.
- busy  out  1  frame held, not fully drained.
- frame_cnt  out  8  completed frames, wraps 255 -> 0.
- order_err  out  1  sticky order violation (optional feature).

Behaviour:
- Reset (async, rst_n = 0), all registers clear immediately:
  - state = IDLE; buffer = 0.
  - out_valid = 0; out_data = 0; out_idx = 0; out_last = 0.
  - busy = 0; frame_cnt = 0; order_err = 0.
  - in_ready = 1 after reset, because it is decoded from state.
- Frame capture:
  - in_ready = (state == IDLE). Combinational from state only; never depends on in_valid.
  - IDLE, in_valid = 1: capture all NUM values into the buffer at that edge.
  - Same edge: state -> SEND, out_valid = 1, out_data = buffer[0], out_idx = 0, out_last = (NUM == 1), busy = 1.
  - Latency from frame transfer to first out_valid is 1 cycle.
- SEND, out_valid = 1, out_ready = 0:
  - out_data, out_idx and out_last hold stable; nothing changes.
  - in_data changes are ignored.
- SEND, out_ready = 1, out_idx < NUM-1:
  - out_idx advances by 1; out_data = buffer[out_idx+1].
  - out_last = (out_idx+1 == NUM-1).
  - One beat per cycle under continuous out_ready.
- SEND, out_ready = 1, out_idx == NUM-1:
  - state -> IDLE; out_valid, out_last and busy clear; out_idx -> 0.
  - frame_cnt increments modulo 256.
- No overlap between frames:
  - The next frame can be accepted only in the cycle after the last beat (in_ready high again).
  - Minimum frame period is NUM+1 cycles.
- Duplicate values are emitted unchanged; no merging.
- Reset mid-frame discards the buffer and the remaining beats. No partial out_last is produced.
- State machine: IDLE -> SEND on in_valid; SEND -> IDLE on the last accepted beat. No other transitions.

Optional Feature:
- Macro SORTED_DRAIN_CHECK_EN.
- When defined:
  - At each capture, compare adjacent values (unsigned) in the incoming frame.
  - If any nK < n(K+1), set order_err = 1 at the capture edge.
  - order_err stays set until rst_n asserts.
  - Data is still streamed unmodified.
- When undefined:
  - The comparator logic is not present.
  - order_err is tied to 0.
  - The port list is identical in both builds.

Test Plan:
- Basic drain: reset, then capture {n0..n5} = {900,700,700,300,12,0} with out_ready = 1 -> first out_valid 1 cycle after capture. Beats 900,700,700,300,12,0 with out_idx 0..5; out_last only on 0; frame_cnt = 1; in_ready high again the following cycle.
- Backpressure: same frame, out_ready low on cycles 2-4 of the drain -> out_data 700 / out_idx 1 held stable across the stall. No beat lost or repeated; 6 beats total.
- Frame ignored while busy: pulse in_valid with {1,1,1,1,1,1} during SEND -> in_ready = 0, buffer unchanged, original values still emitted.
- Reset mid-frame: assert rst_n low after beat 2 -> out_valid = 0 immediately, frame_cnt = 0, in_ready = 1 after release. A new frame {5,4,3,2,1,0} drains correctly.
- Counter wrap: stream 256 back-to-back frames -> frame_cnt reads 255 after frame 255 and 0 after frame 256.
- Check feature (SORTED_DRAIN_CHECK_EN defined): frame {10,20,5,4,3,2} -> order_err = 1 at the capture edge and stays high through later valid frames. With the macro undefined, the same stimulus gives order_err = 0.

Source files
------------

// File: rtl/sorted_drain.sv
// Sort-network consumer: captures one NUM-value frame and replays it as a
// descending serial stream. Optional order checker under SORTED_DRAIN_CHECK_EN.
module sorted_drain #(
    parameter int DATA_W = 10,
    parameter int NUM    = 6,
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM*DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic [7:0]            frame_cnt,
    output logic                  order_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    logic [0:0]                   state;
    logic [NUM-1:0][DATA_W-1:0]   buffer;
    logic [IDX_W-1:0]             next_idx;
    logic                         capture;

    assign in_ready = (state == IDLE);
    assign capture  = in_ready && in_valid;
    assign next_idx = out_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            buffer    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                // First beat comes straight from the bus; the buffer is loaded on this same edge.
                buffer    <= in_data;
                state     <= SEND;
                out_valid <= 1'b1;
                out_data  <= in_data[DATA_W-1:0];
                out_idx   <= '0;
                out_last  <= (NUM == 1);
                busy      <= 1'b1;
            end
        end else if (out_ready) begin
            if (out_idx == LAST_IDX) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                out_idx   <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                out_idx   <= next_idx;
                out_data  <= buffer[next_idx];
                out_last  <= (next_idx == LAST_IDX);
            end
        end
    end

`ifdef SORTED_DRAIN_CHECK_EN
    logic unsorted;

    // Any adjacent pair rising towards the small end means the sorter misbehaved.
    always_comb begin
        unsorted = 1'b0;
        for (int k = 0; k < NUM - 1; k++) begin
            if (in_data[k*DATA_W +: DATA_W] < in_data[(k+1)*DATA_W +: DATA_W])
                unsorted = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            order_err <= 1'b0;
        else if (capture && unsorted)
            order_err <= 1'b1;
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign order_err      = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_drain.sv
// Directed bench for sorted_drain: drain, backpressure, ignored frame,
// mid-frame reset, counter wrap and the optional order checker.
module tb_sorted_drain;

    localparam int DATA_W = 10;
    localparam int NUM    = 6;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM*DATA_W-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [2:0]            out_idx;
    logic                  out_last;
    logic                  busy;
    logic [7:0]            frame_cnt;
    logic                  order_err;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef SORTED_DRAIN_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    sorted_drain #(.DATA_W(DATA_W), .NUM(NUM)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy),
        .frame_cnt(frame_cnt), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM*DATA_W-1:0] pack6(input int a, b, c, d, e, f);
        logic [NUM*DATA_W-1:0] r;
        r = {DATA_W'(f), DATA_W'(e), DATA_W'(d), DATA_W'(c), DATA_W'(b), DATA_W'(a)};
        return r;
    endfunction

    task automatic capture(input logic [NUM*DATA_W-1:0] fr);
        in_valid = 1'b1;
        in_data  = fr;
        chk("cap_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Expected beat k is fr[k]; stall bit c drops out_ready on drain cycle c.
    task automatic drain(input logic [NUM*DATA_W-1:0] fr, input logic [31:0] stall, input int inj);
        int beat = 0;
        for (int c = 0; c < 32 && beat < NUM; c++) begin
            out_ready = !stall[c];
            in_valid  = (c == inj);
            if (c == inj) begin
                in_data = '1;
                chk("ign_rdy", in_ready, 0);
            end
            chk("vld",  out_valid, 1);
            chk("data", out_data, fr[beat*DATA_W +: DATA_W]);
            chk("idx",  out_idx, beat);
            chk("last", out_last, beat == NUM - 1);
            chk("busy", busy, 1);
            if (out_ready) beat++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("beats",    beat, NUM);
        chk("done_vld", out_valid, 0);
        chk("done_bsy", busy, 0);
        chk("done_rdy", in_ready, 1);
    endtask

    logic [NUM*DATA_W-1:0] f_basic, f_small, f_bad;

    initial begin
        f_basic = pack6(900, 700, 700, 300, 12, 0);
        f_small = pack6(5, 4, 3, 2, 1, 0);
        f_bad   = pack6(10, 20, 5, 4, 3, 2);
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_vld",  out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx",  out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt",  frame_cnt, 0);
        chk("rst_err",  order_err, 0);
        chk("rst_rdy",  in_ready, 1);
        rst_n = 1'b1;
        step();

        // basic drain, then backpressure, then an ignored frame while busy
        capture(f_basic);
        drain(f_basic, 32'h0, -1);
        chk("cnt1", frame_cnt, 1);
        chk("err_ok", order_err, 0);
        capture(f_basic);
        drain(f_basic, 32'b1110, -1);
        chk("cnt2", frame_cnt, 2);
        capture(f_basic);
        drain(f_basic, 32'b0100, 2);
        chk("cnt3", frame_cnt, 3);

        // reset while beat 2 is presented
        capture(f_basic);
        step(); step();
        chk("pre_rst_idx", out_idx, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_vld",  out_valid, 0);
        chk("mrst_cnt",  frame_cnt, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_rdy",  in_ready, 1);
        #3 rst_n = 1'b1;
        step();
        chk("post_rdy", in_ready, 1);
        capture(f_small);
        drain(f_small, 32'h0, -1);
        chk("cnt_after_rst", frame_cnt, 1);

        // counter wrap over 256 back-to-back frames
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        for (int i = 1; i <= 256; i++) begin
            capture(f_small);
            drain(f_small, 32'h0, -1);
            if (i == 255) chk("cnt255", frame_cnt, 255);
        end
        chk("cnt_wrap", frame_cnt, 0);

        // order checker
        capture(f_bad);
        chk("err_cap", order_err, ERR_EXP);
        drain(f_bad, 32'h0, -1);
        capture(f_basic);
        drain(f_basic, 32'h0, -1);
        chk("err_sticky", order_err, ERR_EXP);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
